// File: rtl/vec_pkg.sv
// Shared types and sizes for the multiply vector bank write-side packer.
package vec_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned GRP_W  = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } pack_state_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/vec_result_packer.sv
// Packs scalar results into 4-lane groups and issues one-cycle bank writes.
// Group 0 lands in the lower half of the bank, group 1 in the upper half.
// Optional build macro VEC_PACK_ZERO_PAD_EN: zero the unfilled lanes of a
// group closed early by in_last (otherwise those lanes carry stale data).
module vec_result_packer
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              we,
  output logic              wr_mul_pos,
  output logic [WORD_W-1:0] wd1,
  output logic [WORD_W-1:0] wd2,
  output logic [WORD_W-1:0] wd3,
  output logic [WORD_W-1:0] wd4,
  output logic              bank_full,
  output logic [1:0]        grp_cnt
);

  pack_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_b;
  logic               half_q, half_d;
  logic               last_q, last_d;
  word_t              lane_q [LANES];
  word_t              lane_d [LANES];
  word_t              wd_q   [LANES];
  word_t              wd_d   [LANES];
  logic               we_q, we_d;
  logic               pos_q, pos_d;
  logic               full_q, full_d;
  logic [GRP_W-1:0]   grp_q, grp_d;

  // Accept only while filling; depends on state alone.
  assign in_ready   = (state_q == FILL);
  assign we         = we_q;
  assign wr_mul_pos = pos_q;
  assign wd1        = wd_q[0];
  assign wd2        = wd_q[1];
  assign wd3        = wd_q[2];
  assign wd4        = wd_q[3];
  assign bank_full  = full_q;
  assign grp_cnt    = grp_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idx_b   = idx_q;
    half_d  = half_q;
    last_d  = last_q;
    lane_d  = lane_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    pos_d   = pos_q;
    full_d  = full_q;
    grp_d   = grp_q;

    case (state_q)
      FILL: begin
        if (clear) begin
          idx_b  = '0;
          idx_d  = '0;
          half_d = 1'b0;
          grp_d  = '0;
        end
        if (in_valid) begin
          lane_d[idx_b] = in_data;
          if (idx_b == IDX_W'(LANES - 1) || in_last) begin
            state_d = WRITE;
            we_d    = 1'b1;
            pos_d   = half_d;
            grp_d   = grp_d + GRP_W'(1);
            last_d  = in_last;
            idx_d   = '0;
            wd_d    = lane_d;
`ifdef VEC_PACK_ZERO_PAD_EN
            for (int i = 0; i < LANES; i++) begin
              if (IDX_W'(i) > idx_b) wd_d[i] = '0;
            end
`endif
          end else begin
            idx_d = idx_b + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        if (half_q || last_q) begin
          state_d = FULL;
          full_d  = 1'b1;
        end else begin
          state_d = FILL;
          half_d  = 1'b1;
          idx_d   = '0;
        end
      end
      FULL: begin
        if (clear) begin
          state_d = FILL;
          half_d  = 1'b0;
          idx_d   = '0;
          grp_d   = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      pos_q   <= 1'b0;
      full_q  <= 1'b0;
      grp_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
        wd_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      last_q  <= last_d;
      we_q    <= we_d;
      pos_q   <= pos_d;
      full_q  <= full_d;
      grp_q   <= grp_d;
      lane_q  <= lane_d;
      wd_q    <= wd_d;
    end
  end

endmodule
